// File: rtl/monster_slot_if.sv
// Allocator <-> slot bundle: spawn/damage/movement strobes in, status and position out.
interface monster_slot_if;
    logic        frame_tick;
    logic        enable;
    logic [2:0]  summon_type;
    logic        hit;
    logic [7:0]  damage;
    logic        used;
    logic [2:0]  occur;
    logic [31:0] offx;
    logic [31:0] offy;
    logic        achieve;
    logic [7:0]  hp;

    modport master (
        output frame_tick, enable, summon_type, hit, damage,
        input  used, occur, offx, offy, achieve, hp
    );

    modport slave (
        input  frame_tick, enable, summon_type, hit, damage,
        output used, occur, offx, offy, achieve, hp
    );
endinterface

// File: rtl/monster_slot.sv
// One monster engine: spawns on an allocator request, walks a fixed 4-waypoint
// path one step per frame, takes tower damage, and retires for good at the goal.
module monster_slot #(
    parameter logic [31:0] WP0_X = 32'd0,
    parameter logic [31:0] WP0_Y = 32'd240,
    parameter logic [31:0] WP1_X = 32'd320,
    parameter logic [31:0] WP1_Y = 32'd240,
    parameter logic [31:0] WP2_X = 32'd320,
    parameter logic [31:0] WP2_Y = 32'd80,
    parameter logic [31:0] WP3_X = 32'd639,
    parameter logic [31:0] WP3_Y = 32'd80
) (
    input  logic           Clk,
    input  logic           Reset_n,
    monster_slot_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, WALK, DEAD, GOAL} state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [2:0]  r_type;
    logic [1:0]  r_wpIdx;
    logic [31:0] r_offx;
    logic [31:0] r_offy;
    logic [7:0]  r_hp;

    logic        w_spawn;
    logic        w_kill;
    logic        w_move;
    logic        w_arrive;
    logic [31:0] w_speed;
    logic [31:0] w_tgtX;
    logic [31:0] w_tgtY;
    logic [31:0] w_stepX;
    logic [31:0] w_stepY;
    logic [7:0]  w_spawnHp;

    // Step toward the target by spd, landing exactly on it rather than overshooting.
    function automatic logic [31:0] stepToward(input logic [31:0] cur,
                                               input logic [31:0] tgt,
                                               input logic [31:0] spd);
        if (cur < tgt)
            return ((tgt - cur) <= spd) ? tgt : cur + spd;
        else if (cur > tgt)
            return ((cur - tgt) <= spd) ? tgt : cur - spd;
        else
            return cur;
    endfunction

    always_comb begin
        w_tgtX = WP0_X;
        w_tgtY = WP0_Y;
        case (r_wpIdx)
            2'd0: begin w_tgtX = WP0_X; w_tgtY = WP0_Y; end
            2'd1: begin w_tgtX = WP1_X; w_tgtY = WP1_Y; end
            2'd2: begin w_tgtX = WP2_X; w_tgtY = WP2_Y; end
            default: begin w_tgtX = WP3_X; w_tgtY = WP3_Y; end
        endcase
    end

    always_comb begin
        w_spawnHp = 8'd80;
        case (bus.summon_type)
            3'd1:    w_spawnHp = 8'd10;
            3'd2:    w_spawnHp = 8'd20;
            3'd3:    w_spawnHp = 8'd40;
            default: w_spawnHp = 8'd80;
        endcase
    end

    // A kill suppresses movement, so a kill on the final step never reaches GOAL.
    assign w_spawn  = (r_state == IDLE) && bus.enable && (bus.summon_type != 3'd0);
    assign w_kill   = (r_state == WALK) && bus.hit && (bus.damage >= r_hp);
    assign w_move   = (r_state == WALK) && bus.frame_tick && !w_kill;
    assign w_speed  = (r_type == 3'd1) ? 32'd2 : 32'd1;
    assign w_stepX  = (r_offx != w_tgtX) ? stepToward(r_offx, w_tgtX, w_speed) : r_offx;
    assign w_stepY  = (r_offx != w_tgtX) ? r_offy : stepToward(r_offy, w_tgtY, w_speed);
    assign w_arrive = w_move && (w_stepX == w_tgtX) && (w_stepY == w_tgtY);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            r_state <= IDLE;
        else
            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_spawn) w_nextState = WALK;
            WALK: begin
                if (w_kill)
                    w_nextState = DEAD;
                else if (w_arrive && (r_wpIdx == 2'd3))
                    w_nextState = GOAL;
            end
            DEAD:    w_nextState = IDLE;
            default: w_nextState = GOAL;
        endcase
    end

    always_comb begin
        bus.used    = (r_state != IDLE);
        bus.occur   = (r_state == WALK) ? r_type : 3'd0;
        bus.achieve = (r_state == GOAL);
        bus.offx    = r_offx;
        bus.offy    = r_offy;
        bus.hp      = r_hp;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_type  <= 3'd0;
            r_wpIdx <= 2'd0;
            r_offx  <= 32'd0;
            r_offy  <= 32'd0;
            r_hp    <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_spawn) begin
                        r_type  <= bus.summon_type;
                        r_wpIdx <= 2'd1;
                        r_offx  <= WP0_X;
                        r_offy  <= WP0_Y;
                        r_hp    <= w_spawnHp;
                    end
                end
                WALK: begin
                    if (w_kill) begin
                        r_hp <= 8'd0;
                    end else begin
                        if (bus.hit)
                            r_hp <= r_hp - bus.damage;
                        if (w_move) begin
                            r_offx <= w_stepX;
                            r_offy <= w_stepY;
                            if (w_arrive && (r_wpIdx != 2'd3))
                                r_wpIdx <= r_wpIdx + 2'd1;
                        end
                    end
                end
                DEAD:    r_hp <= 8'd0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_monster_slot.sv
// Directed and randomized checks of monster_slot against a path/HP reference model.
module tb_monster_slot;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;

    monster_slot_if bus ();

    monster_slot dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    int vectorCount = 0;
    int failCount   = 0;

    int pathX [4] = '{0, 320, 320, 639};
    int pathY [4] = '{240, 240, 80, 80};
    int hpTable [8] = '{0, 10, 20, 40, 80, 80, 80, 80};

    // Model: a monster is either absent, alive on leg mLeg, in its one death cycle, or at the goal.
    bit mAlive, mDeadPulse, mGoal;
    int mType, mX, mY, mHp, mLeg;

    function automatic int moveToward(input int cur, input int tgt, input int spd);
        if (cur < tgt) return (tgt - cur < spd) ? tgt : cur + spd;
        if (cur > tgt) return (cur - tgt < spd) ? tgt : cur - spd;
        return cur;
    endfunction

    task automatic resetModel();
        mAlive = 0; mDeadPulse = 0; mGoal = 0;
        mType = 0; mX = 0; mY = 0; mHp = 0; mLeg = 0;
    endtask

    task automatic modelStep(input bit fe, input bit en, input int ty, input bit h, input int dmg);
        int spd;
        if (mGoal) begin
        end else if (mDeadPulse) begin
            mDeadPulse = 0;
            mHp = 0;
        end else if (!mAlive) begin
            if (en && ty != 0) begin
                mAlive = 1; mType = ty; mX = pathX[0]; mY = pathY[0];
                mLeg = 1; mHp = hpTable[ty];
            end
        end else if (h && dmg >= mHp) begin
            mAlive = 0; mDeadPulse = 1; mHp = 0;
        end else begin
            if (h) mHp = mHp - dmg;
            if (fe) begin
                spd = (mType == 1) ? 2 : 1;
                if (mX != pathX[mLeg]) mX = moveToward(mX, pathX[mLeg], spd);
                else                   mY = moveToward(mY, pathY[mLeg], spd);
                if (mX == pathX[mLeg] && mY == pathY[mLeg]) begin
                    if (mLeg == 3) begin mGoal = 1; mAlive = 0; end
                    else mLeg++;
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectorCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".used"},    32'(bus.used),    32'(mAlive || mDeadPulse || mGoal));
        checkOutput({tag, ".occur"},   32'(bus.occur),   mAlive ? 32'(mType) : 32'd0);
        checkOutput({tag, ".offx"},    bus.offx,         32'(mX));
        checkOutput({tag, ".offy"},    bus.offy,         32'(mY));
        checkOutput({tag, ".achieve"}, 32'(bus.achieve), 32'(mGoal));
        checkOutput({tag, ".hp"},      32'(bus.hp),      32'(mHp));
    endtask

    // Drives one cycle of inputs shortly after an edge, advances the model, checks after the next edge.
    task automatic applyStimulus(input string tag, input logic fe, input logic en,
                                 input logic [2:0] ty, input logic h, input logic [7:0] dmg);
        bus.frame_tick  = fe;
        bus.enable      = en;
        bus.summon_type = ty;
        bus.hit         = h;
        bus.damage      = dmg;
        modelStep(fe, en, int'(ty), h, int'(dmg));
        @(posedge Clk);
        #1;
        checkAll(tag);
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) applyStimulus(tag, 1'b1, 1'b0, 3'd0, 1'b0, 8'd0);
    endtask

    // Reset is pulsed between edges and the outputs must clear before any clock arrives.
    task automatic resetDut(input string tag);
        bus.frame_tick = 0; bus.enable = 0; bus.summon_type = 0; bus.hit = 0; bus.damage = 0;
        #2 Reset_n = 1'b0;
        #1;
        checkOutput({tag, ".used"},    32'(bus.used),    32'd0);
        checkOutput({tag, ".occur"},   32'(bus.occur),   32'd0);
        checkOutput({tag, ".achieve"}, 32'(bus.achieve), 32'd0);
        checkOutput({tag, ".hp"},      32'(bus.hp),      32'd0);
        checkOutput({tag, ".offx"},    bus.offx,         32'd0);
        checkOutput({tag, ".offy"},    bus.offy,         32'd0);
        #1 Reset_n = 1'b1;
        resetModel();
        @(posedge Clk);
        #1;
        checkAll({tag, ".idle"});
    endtask

    initial begin
        bus.frame_tick = 0; bus.enable = 0; bus.summon_type = 0; bus.hit = 0; bus.damage = 0;
        resetModel();
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
        checkAll("reset");

        applyStimulus("enType0", 1'b0, 1'b1, 3'd0, 1'b0, 8'd0);
        checkOutput("enType0.usedConst", 32'(bus.used), 32'd0);
        applyStimulus("hitIdle", 1'b0, 1'b0, 3'd0, 1'b1, 8'd50);
        checkOutput("hitIdle.hpConst", 32'(bus.hp), 32'd0);

        applyStimulus("spawn2", 1'b0, 1'b1, 3'd2, 1'b0, 8'd0);
        checkOutput("spawn2.occurConst", 32'(bus.occur), 32'd2);
        checkOutput("spawn2.offyConst",  bus.offy,       32'd240);
        checkOutput("spawn2.hpConst",    32'(bus.hp),    32'd20);
        applyStimulus("enWalk", 1'b0, 1'b1, 3'd4, 1'b0, 8'd0);
        checkOutput("enWalk.hpConst",    32'(bus.hp),    32'd20);
        checkOutput("enWalk.occurConst", 32'(bus.occur), 32'd2);
        ticks("walk2", 5);
        checkOutput("walk2.offxConst", bus.offx, 32'd5);
        applyStimulus("hitWalk", 1'b1, 1'b0, 3'd0, 1'b1, 8'd7);
        checkOutput("hitWalk.hpConst", 32'(bus.hp), 32'd13);
        resetDut("asyncReset");

        applyStimulus("spawn1", 1'b0, 1'b1, 3'd1, 1'b0, 8'd0);
        ticks("leg1", 160);
        checkOutput("leg1.offxConst", bus.offx, 32'd320);
        checkOutput("leg1.offyConst", bus.offy, 32'd240);
        ticks("leg2", 80);
        checkOutput("leg2.offyConst", bus.offy, 32'd80);
        ticks("leg3", 159);
        checkOutput("leg3.offxConst", bus.offx, 32'd638);
        applyStimulus("killOnGoal", 1'b1, 1'b0, 3'd0, 1'b1, 8'd200);
        checkOutput("killOnGoal.achieveConst", 32'(bus.achieve), 32'd0);
        checkOutput("killOnGoal.usedConst",    32'(bus.used),    32'd1);
        checkOutput("killOnGoal.occurConst",   32'(bus.occur),   32'd0);
        applyStimulus("afterKill", 1'b0, 1'b0, 3'd0, 1'b0, 8'd0);
        checkOutput("afterKill.usedConst", 32'(bus.used), 32'd0);

        applyStimulus("spawn3", 1'b0, 1'b1, 3'd3, 1'b0, 8'd0);
        applyStimulus("hit15a", 1'b0, 1'b0, 3'd0, 1'b1, 8'd15);
        applyStimulus("hit15b", 1'b0, 1'b0, 3'd0, 1'b1, 8'd15);
        checkOutput("hit15b.hpConst", 32'(bus.hp), 32'd10);
        applyStimulus("hit10", 1'b0, 1'b0, 3'd0, 1'b1, 8'd10);
        checkOutput("hit10.occurConst", 32'(bus.occur), 32'd0);
        checkOutput("hit10.usedConst",  32'(bus.used),  32'd1);
        applyStimulus("deadNext", 1'b0, 1'b1, 3'd5, 1'b0, 8'd0);
        checkOutput("deadNext.usedConst", 32'(bus.used), 32'd0);
        applyStimulus("respawn1", 1'b0, 1'b1, 3'd1, 1'b0, 8'd0);
        checkOutput("respawn1.offxConst", bus.offx, 32'd0);
        checkOutput("respawn1.offyConst", bus.offy, 32'd240);
        ticks("toGoal", 400);
        checkOutput("goal.offxConst",    bus.offx,         32'd639);
        checkOutput("goal.achieveConst", 32'(bus.achieve), 32'd1);
        checkOutput("goal.usedConst",    32'(bus.used),    32'd1);
        applyStimulus("goalEnable", 1'b1, 1'b1, 3'd2, 1'b1, 8'd255);
        checkOutput("goalEnable.occurConst", 32'(bus.occur), 32'd0);

        for (int round = 0; round < 3; round++) begin
            resetDut("randReset");
            for (int i = 0; i < 700; i++) begin
                applyStimulus("rand",
                              1'($urandom_range(0, 3) != 0),
                              1'($urandom_range(0, 15) == 0),
                              3'($urandom_range(0, 7)),
                              1'($urandom_range(0, (round == 1) ? 80 : 9) == 0),
                              8'($urandom_range(0, 40)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end

endmodule
